// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU definitions used by the interrupt controller.
//   irq_state_t           : controller state (RUN, HALT, DISPATCH)
//   IRQ_VEC_*             : low byte of each ISR entry point (high byte is 0x00)
//   DISPATCH_M_CYCLES     : length of the ISR dispatch sequence in M-cycles
//   DISPATCH_RESOLVE_STEP : dispatch step at which the vector is chosen
//   DISPATCH_LAST_STEP    : final dispatch step (PC <= vector)
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    IRQ_RUN      = 2'd0,
    IRQ_HALT     = 2'd1,
    IRQ_DISPATCH = 2'd2
  } irq_state_t;

  localparam logic [7:0] IRQ_VEC_VBLANK = 8'h40;
  localparam logic [7:0] IRQ_VEC_LCD    = 8'h48;
  localparam logic [7:0] IRQ_VEC_TIMER  = 8'h50;
  localparam logic [7:0] IRQ_VEC_SERIAL = 8'h58;
  localparam logic [7:0] IRQ_VEC_JOYPAD = 8'h60;

  localparam int DISPATCH_M_CYCLES = 5;

  localparam logic [2:0] DISPATCH_RESOLVE_STEP = 3'd3;
  localparam logic [2:0] DISPATCH_LAST_STEP    = 3'(DISPATCH_M_CYCLES - 1);

endpackage

// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// Bus between the CPU scheduler and the interrupt controller.
//   master : scheduler side; drives boundary/control bits and IE/IF,
//            receives IME, dispatch sequencing, vector, IF ack, HALT status.
//   slave  : interrupt controller side.
interface gb_cpu_interrupt_ctrl_if;

  logic       instr_boundary_i;
  logic       ei_i;
  logic       di_i;
  logic       reti_i;
  logic       halt_i;
  logic [4:0] ie_i;
  logic [4:0] if_i;

  logic       ime_o;
  logic       dispatch_o;
  logic [2:0] dispatch_m_cycle_o;
  logic [7:0] irq_vector_o;
  logic [4:0] irq_ack_o;
  logic       halted_o;
  logic       halt_bug_o;

  modport master (
    output instr_boundary_i, ei_i, di_i, reti_i, halt_i, ie_i, if_i,
    input  ime_o, dispatch_o, dispatch_m_cycle_o, irq_vector_o, irq_ack_o,
           halted_o, halt_bug_o
  );

  modport slave (
    input  instr_boundary_i, ei_i, di_i, reti_i, halt_i, ie_i, if_i,
    output ime_o, dispatch_o, dispatch_m_cycle_o, irq_vector_o, irq_ack_o,
           halted_o, halt_bug_o
  );

endinterface

// File: rtl/gb_cpu_irq_priority.sv
// Combinational interrupt priority resolver.
//   pending : IE & IF, bit 0 (VBlank) has the highest priority
//   grant   : one-hot of the lowest set pending bit, 0 when none
//   vector  : ISR low address byte for the granted source, 0x00 when none
module gb_cpu_irq_priority
  import gb_cpu_common_pkg::*;
(
  input  logic [4:0] pending,
  output logic [4:0] grant,
  output logic [7:0] vector
);

  always_comb begin
    grant  = 5'b00000;
    vector = 8'h00;
    if (pending[0]) begin
      grant  = 5'b00001;
      vector = IRQ_VEC_VBLANK;
    end else if (pending[1]) begin
      grant  = 5'b00010;
      vector = IRQ_VEC_LCD;
    end else if (pending[2]) begin
      grant  = 5'b00100;
      vector = IRQ_VEC_TIMER;
    end else if (pending[3]) begin
      grant  = 5'b01000;
      vector = IRQ_VEC_SERIAL;
    end else if (pending[4]) begin
      grant  = 5'b10000;
      vector = IRQ_VEC_JOYPAD;
    end
  end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller: IME / delayed EI handling, HALT entry
// and exit (including the HALT bug), and the 5 M-cycle ISR dispatch sequence.
//   clk   : M-cycle clock
//   reset : asynchronous active-low reset
//   bus   : scheduler interface (slave side), see gb_cpu_interrupt_ctrl_if
module gb_cpu_interrupt_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  gb_cpu_interrupt_ctrl_if.slave  bus
);

  irq_state_t state, state_next;
  logic [2:0] step, step_next;
  logic       ime, ime_next, ime_ctl;
  logic       ei_pending, ei_pending_next;
  logic       halt_bug, halt_bug_next;
  logic [7:0] vec_hold, vec_hold_next;

  logic [4:0] pending;
  logic       any_pending;
  logic [4:0] grant;
  logic [7:0] vector;

  assign pending     = bus.ie_i & bus.if_i;
  assign any_pending = |pending;

  gb_cpu_irq_priority u_priority (
    .pending (pending),
    .grant   (grant),
    .vector  (vector)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IRQ_RUN;
      step       <= 3'd0;
      ime        <= 1'b0;
      ei_pending <= 1'b0;
      halt_bug   <= 1'b0;
    end else begin
      state      <= state_next;
      step       <= step_next;
      ime        <= ime_next;
      ei_pending <= ei_pending_next;
      halt_bug   <= halt_bug_next;
    end
  end

  // Vector latch only reaches the output at the last dispatch step, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    vec_hold <= vec_hold_next;
  end

  always_comb begin
    state_next      = state;
    step_next       = step;
    vec_hold_next   = vec_hold;
    halt_bug_next   = 1'b0;
    ime_ctl         = ime;
    ei_pending_next = ei_pending;

    // EI arms a one-boundary delay: the armed flag is consumed at the next
    // boundary and IME becomes visible from the boundary after that. DI
    // overrides EI, RETI and any armed EI.
    if (bus.di_i) begin
      ime_ctl         = 1'b0;
      ei_pending_next = 1'b0;
    end else begin
      if (bus.reti_i) ime_ctl = 1'b1;
      if (ei_pending && bus.instr_boundary_i) begin
        ime_ctl         = 1'b1;
        ei_pending_next = 1'b0;
      end
      if (bus.ei_i) ei_pending_next = 1'b1;
    end
    ime_next = ime_ctl;

    unique case (state)
      IRQ_RUN: begin
        if (bus.instr_boundary_i) begin
          if (ime && any_pending) begin
            state_next = IRQ_DISPATCH;
            step_next  = 3'd0;
            ime_next   = 1'b0;
          end else if (bus.halt_i) begin
            // HALT with IME=0 and a pending interrupt is not entered; the
            // following fetch repeats instead.
            if (ime || !any_pending) state_next    = IRQ_HALT;
            else                     halt_bug_next = 1'b1;
          end
        end
      end
      IRQ_HALT: begin
        if (any_pending) begin
          if (ime) begin
            state_next = IRQ_DISPATCH;
            step_next  = 3'd0;
            ime_next   = 1'b0;
          end else begin
            state_next = IRQ_RUN;
          end
        end
      end
      IRQ_DISPATCH: begin
        ime_next        = ime;
        ei_pending_next = ei_pending;
        if (step == DISPATCH_RESOLVE_STEP) vec_hold_next = vector;
        if (step == DISPATCH_LAST_STEP) begin
          state_next = IRQ_RUN;
          step_next  = 3'd0;
        end else begin
          step_next = step + 3'd1;
        end
      end
      default: begin
        state_next = IRQ_RUN;
        step_next  = 3'd0;
      end
    endcase
  end

  logic in_dispatch, at_resolve, at_last;
  assign in_dispatch = (state == IRQ_DISPATCH);
  assign at_resolve  = in_dispatch && (step == DISPATCH_RESOLVE_STEP);
  assign at_last     = in_dispatch && (step == DISPATCH_LAST_STEP);

  assign bus.ime_o              = ime;
  assign bus.dispatch_o         = in_dispatch;
  assign bus.dispatch_m_cycle_o = in_dispatch ? step : 3'd0;
  // The vector is resolved from live IE&IF at step 3 (the push may have
  // overwritten IE) and held through step 4.
  assign bus.irq_vector_o       = at_resolve ? vector : (at_last ? vec_hold : 8'h00);
  assign bus.irq_ack_o          = at_resolve ? grant : 5'b00000;
  assign bus.halted_o           = (state == IRQ_HALT);
  assign bus.halt_bug_o         = halt_bug;

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
GB_CPU_INTERRUPT_CTRL -- requirements
Module: gb_cpu_interrupt_ctrl

Interface
REQ-001 SHALL: clk  input  1  Machine (M) clock; all state updates on posedge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low system reset.
REQ-003 SHALL: instr_boundary_i  input  1  high in the M-cycle where the scheduler fetches the next opcode (curr_m_cycle==0).
REQ-004 SHALL: ei_i  input  1  enable_interrupts control bit of the executing M-cycle.
REQ-005 SHALL: di_i  input  1  disable_interrupts control bit of the executing M-cycle.
REQ-006 SHALL: reti_i  input  1  RETI final M-cycle; sets IME with no delay.
REQ-007 SHALL: halt_i  input  1  HALT opcode decoded at a boundary.
REQ-008 SHALL: ie_i  input  5  IE register bits [4:0].
REQ-009 SHALL: if_i  input  5  IF register bits [4:0].
REQ-010 SHALL: ime_o  output  1  interrupt master enable.
REQ-011 SHALL: dispatch_o  output  1  high for all 5 dispatch M-cycles; scheduler selects the ISR schedule.
REQ-012 SHALL: dispatch_m_cycle_o  output  3  dispatch step 0..4.
REQ-013 SHALL: irq_vector_o  output  8  low byte of ISR target; high byte always 0x00.
REQ-014 SHALL: irq_ack_o  output  5  one-hot IF clear pulse.
REQ-015 SHALL: halted_o  output  1  CPU in HALT; fetch suppressed.
REQ-016 SHALL: halt_bug_o  output  1  one-cycle pulse: next fetch must not increment PC.

Function
REQ-017 SHALL: pending = ie_i & if_i; any_pending = |pending.
REQ-018 SHALL: states RUN, HALT, DISPATCH; DISPATCH uses 3-bit step counter 0..4.
REQ-019 SHALL: EI sets ei_pending; IME rises at the second instruction boundary after EI, i.e. after the following instruction completes; no dispatch is taken at the first boundary.
REQ-020 SHALL: DI clears IME and ei_pending in the same cycle; DI and EI in the same cycle: DI wins.
REQ-021 SHALL: RETI sets IME on the next edge, with no delay.
REQ-022 SHALL: RUN->DISPATCH at instr_boundary_i with IME=1 and any_pending=1; IME cleared on entry; step=0.
REQ-023 SHALL: dispatch steps: 0 PC decrement, 1 SP decrement, 2 push PCH, 3 push PCL plus vector resolve, 4 PC<=vector; after step 4, return to RUN.
REQ-024 SHALL: vector resolved at step 3 from pending at that cycle; lowest set bit wins, giving 0x40/0x48/0x50/0x58/0x60; irq_ack_o asserts that bit for exactly that cycle.
REQ-025 SHALL: if pending==0 at step 3 (IE overwritten by the push), irq_vector_o=0x00, irq_ack_o=0, and dispatch still completes.
REQ-026 SHALL: irq_vector_o holds its value from step 3 through step 4; it is 0x00 otherwise.
REQ-027 SHALL: RUN->HALT at instr_boundary_i with halt_i and (IME=1 or any_pending=0).
REQ-028 SHALL: halt_i with IME=0 and any_pending=1 does not enter HALT; halt_bug_o pulses for one cycle instead.
REQ-029 SHALL: HALT exits on any_pending regardless of IME; IME=1 goes to DISPATCH and IME=0 goes to RUN; exit takes 1 cycle.
REQ-030 SHALL: ei_i/di_i/reti_i are ignored during DISPATCH; halt_i is ignored outside instr_boundary_i.

Reset
REQ-031 SHALL: reset low forces state RUN, IME=0, ei_pending=0, step=0, and all outputs 0, immediately and regardless of clk, including mid-dispatch.
REQ-032 SHALL: first edge after reset release behaves as RUN with no pending EI.

Structure
REQ-033 SHALL: gb_cpu_common_pkg gains the irq_state_t enum, the IRQ_VEC_* constants and DISPATCH_M_CYCLES=5.
REQ-034 SHALL: a combinational sub-module gb_cpu_irq_priority (5-bit pending in; one-hot grant and vector out) is instantiated once.

Verification
REQ-035 SHALL: IE=0x1F, IF=0x14, IME=1, boundary -> dispatch_o high for 5 cycles; step 3 gives vector 0x50, irq_ack_o=0x04; IME=0 after.
REQ-036 SHALL: EI, then one 1-cycle instruction with IE=IF=0x01 -> no dispatch at the first boundary, dispatch at the second, vector 0x40.
REQ-037 SHALL: HALT with IME=0, pending=0 -> halted_o=1; set IF=0x02 with IE=0x02 -> halted_o=0 the next cycle, RUN, no dispatch.
REQ-038 SHALL: HALT with IME=0, IE=IF=0x08 -> halt_bug_o pulses once, halted_o stays 0.
REQ-039 SHALL: dispatch with IE forced to 0x00 before step 3 -> vector 0x00, irq_ack_o=0, 5 cycles complete.
REQ-040 SHALL: reset asserted at dispatch step 2 -> all outputs 0 asynchronously; RUN, IME=0 after release.
